// File: rtl/axi_stream_pattern_pkg.sv
// Shared types and LFSR helpers for the multi-channel AXI-Stream pattern source.
// Galois taps are right-shift masks: polynomial exponent e maps to mask bit e-1.
package axi_stream_pattern_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        LFSR  = 2'd1,
        CONST = 2'd2
    } pattern_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            default: return 32'h8020_0003;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int width);
        return s[0] ? ((s >> 1) ^ lfsr_taps(width)) : (s >> 1);
    endfunction

    // Encoding 3 is an alias of COUNT.
    function automatic pattern_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return LFSR;
            2'd2:    return CONST;
            default: return COUNT;
        endcase
    endfunction

endpackage

// File: rtl/axi_stream_lfsr.sv
// Maximal-length Galois LFSR that steps once per cycle with advance high.
// A non-zero seed keeps the all-zero lock-up state unreachable.
module axi_stream_lfsr
    import axi_stream_pattern_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q, state_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = WIDTH'(lfsr_step(32'(state_q), WIDTH));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/axi_stream_pattern_gen.sv
// Multi-channel AXI-Stream test-pattern source: channel-interleaved beats, tid = channel,
// tlast closes each frame; per-channel counter, shared LFSR or constant payload.
module axi_stream_pattern_gen
    import axi_stream_pattern_pkg::*;
#(
    parameter int                   DATA_BITS     = 32,
    parameter longint unsigned      RANGE         = 64'd1 << DATA_BITS,
    parameter int                   CHANNELS      = 4,
    parameter int                   FRAME_SAMPLES = 16,
    parameter logic [DATA_BITS-1:0] LFSR_SEED     = DATA_BITS'(1),
    parameter int                   CH_BITS       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DATA_BITS-1:0] const_value,
    output logic                 tvalid,
    input  logic                 tready,
    output logic [DATA_BITS-1:0] tdata,
    output logic [CH_BITS-1:0]   tid,
    output logic                 tlast,
    output logic [31:0]          frames_sent
);

    localparam int                 K_BITS  = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
    localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(CHANNELS - 1);
    localparam logic [K_BITS-1:0]  LAST_K  = K_BITS'(FRAME_SAMPLES - 1);
    localparam logic [63:0]        CNT_MAX = RANGE - 64'd1;

    state_e                 state_q, state_d;
    pattern_mode_e          mode_q, mode_d;
    logic [CH_BITS-1:0]     ch_q, ch_d;
    logic [K_BITS-1:0]      k_q, k_d;
    logic [DATA_BITS-1:0]   cnt_q [CHANNELS];
    logic [DATA_BITS-1:0]   cnt_d [CHANNELS];
    logic [DATA_BITS-1:0]   tdata_q, tdata_d;
    logic [CH_BITS-1:0]     tid_q, tid_d;
    logic                   tlast_q, tlast_d;
    logic [31:0]            frames_q, frames_d;
    logic                   load;
    logic                   lfsr_adv;
    logic [DATA_BITS-1:0]   lfsr_state, lfsr_next;

    axi_stream_lfsr #(
        .WIDTH (DATA_BITS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        ch_d     = ch_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tid_d    = tid_q;
        tlast_d  = tlast_q;
        frames_d = frames_q;
        load     = 1'b0;
        lfsr_adv = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    ch_d    = '0;
                    k_d     = '0;
                    mode_d  = decode_mode(mode);
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (tready) begin
                    if (mode_q == COUNT) begin
                        cnt_d[ch_q] = (64'(cnt_q[ch_q]) == CNT_MAX) ? '0
                                                                   : cnt_q[ch_q] + DATA_BITS'(1);
                    end
                    lfsr_adv = (mode_q == LFSR);
                    if (tlast_q) begin
                        frames_d = frames_q + 32'd1;
                        ch_d     = '0;
                        k_d      = '0;
                        if (enable) begin
                            mode_d = decode_mode(mode);
                            load   = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tlast_d = 1'b0;
                        end
                    end else begin
                        if (ch_q == LAST_CH) begin
                            ch_d = '0;
                            k_d  = k_q + K_BITS'(1);
                        end else begin
                            ch_d = ch_q + CH_BITS'(1);
                        end
                        load = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // The next beat must see the LFSR value after this cycle's step, if any.
        lfsr_next = lfsr_adv ? DATA_BITS'(lfsr_step(32'(lfsr_state), DATA_BITS)) : lfsr_state;

        if (load) begin
            tid_d   = ch_d;
            tlast_d = (ch_d == LAST_CH) && (k_d == LAST_K);
            case (mode_d)
                COUNT:   tdata_d = cnt_d[ch_d];
                LFSR:    tdata_d = lfsr_next;
                default: tdata_d = const_value;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= COUNT;
            ch_q     <= '0;
            k_q      <= '0;
            tdata_q  <= '0;
            tid_q    <= '0;
            tlast_q  <= 1'b0;
            frames_q <= '0;
            // NOTE: the counter array is reset element by element because its start values are observable.
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= DATA_BITS'(64'(i) % RANGE);
            end
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            ch_q     <= ch_d;
            k_q      <= k_d;
            tdata_q  <= tdata_d;
            tid_q    <= tid_d;
            tlast_q  <= tlast_d;
            frames_q <= frames_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tvalid      = (state_q == RUN);
    assign tdata       = tdata_q;
    assign tid         = tid_q;
    assign tlast       = tlast_q;
    assign frames_sent = frames_q;

`ifdef FORMAL
    logic [DATA_BITS-1:0] f_cnt_q [CHANNELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                f_cnt_q[i] <= DATA_BITS'(64'(i) % RANGE);
            end
        end else if (tvalid && tready && mode_q == COUNT) begin
            f_cnt_q[tid] <= (64'(f_cnt_q[tid]) == CNT_MAX) ? '0 : f_cnt_q[tid] + DATA_BITS'(1);
        end
    end

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (tvalid && !tready) |=> (tvalid && $stable(tdata) && $stable(tid) && $stable(tlast)));
    a_reset: assert property (@(posedge clk)
        rst |=> (!tvalid && !tlast && tid == '0 && tdata == '0 && frames_sent == '0));
    a_count: assert property (@(posedge clk) disable iff (rst)
        (tvalid && mode_q == COUNT) |-> (tdata == f_cnt_q[tid]));
    a_lfsr_nz: assert property (@(posedge clk) disable iff (rst) lfsr_state != '0);
    a_tlast: assert property (@(posedge clk) disable iff (rst)
        tvalid |-> (tlast == (ch_q == LAST_CH && k_q == LAST_K)));
`endif

endmodule

// File: tb/tb_axi_stream_pattern_gen.sv
// Randomised bench: a frame-level reference model predicts each presented beat,
// plus a directed RANGE=5 single-channel wrap check on a second instance.
module tb_axi_stream_pattern_gen;

    localparam int NCH   = 4;
    localparam int NFS   = 2;
    localparam int NBEAT = NCH * NFS;
    localparam logic [7:0] POLY8 = 8'b1011_1000;  // x^8 + x^6 + x^5 + x^4 + 1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 8-bit, 4 channels x 2 samples, full-range counters
    logic        a_rst = 1'b1, a_enable = 1'b0, a_tready = 1'b0;
    logic [1:0]  a_mode = 2'd0;
    logic [7:0]  a_const = 8'h00;
    logic        a_tvalid, a_tlast;
    logic [7:0]  a_tdata;
    logic [1:0]  a_tid;
    logic [31:0] a_frames;

    axi_stream_pattern_gen #(
        .DATA_BITS     (8),
        .CHANNELS      (NCH),
        .FRAME_SAMPLES (NFS),
        .LFSR_SEED     (8'd1)
    ) u_a (
        .clk         (clk),
        .rst         (a_rst),
        .enable      (a_enable),
        .mode        (a_mode),
        .const_value (a_const),
        .tvalid      (a_tvalid),
        .tready      (a_tready),
        .tdata       (a_tdata),
        .tid         (a_tid),
        .tlast       (a_tlast),
        .frames_sent (a_frames)
    );

    // Instance B: RANGE=5, single channel, 3 samples per frame
    logic        b_rst = 1'b1, b_enable = 1'b0, b_tready = 1'b0;
    logic [1:0]  b_mode = 2'd0;
    logic [15:0] b_const = 16'h0000;
    logic        b_tvalid, b_tlast;
    logic [15:0] b_tdata;
    logic [0:0]  b_tid;
    logic [31:0] b_frames;

    axi_stream_pattern_gen #(
        .DATA_BITS     (16),
        .RANGE         (64'd5),
        .CHANNELS      (1),
        .FRAME_SAMPLES (3)
    ) u_b (
        .clk         (clk),
        .rst         (b_rst),
        .enable      (b_enable),
        .mode        (b_mode),
        .const_value (b_const),
        .tvalid      (b_tvalid),
        .tready      (b_tready),
        .tdata       (b_tdata),
        .tid         (b_tid),
        .tlast       (b_tlast),
        .frames_sent (b_frames)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: stream position as a beat index within the frame
    bit         m_valid;
    bit         m_after_rst;
    int         m_beat;
    int         m_mode;      // 0 counter, 1 lfsr, 2 constant
    int         m_cnt [NCH];
    logic [7:0] m_lfsr;
    logic [31:0] m_frames;
    logic [7:0] m_data;

    function automatic int dec_mode(input logic [1:0] m);
        return (m == 2'd1) ? 1 : (m == 2'd2) ? 2 : 0;
    endfunction

    function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ POLY8) : (s >> 1);
    endfunction

    task automatic model_load();
        int ch;
        ch = m_beat % NCH;
        case (m_mode)
            0:       m_data = 8'(m_cnt[ch]);
            1:       m_data = m_lfsr;
            default: m_data = a_const;
        endcase
    endtask

    task automatic model_edge();
        int ch;
        if (a_rst) begin
            m_valid = 1'b0; m_beat = 0; m_mode = 0; m_lfsr = 8'd1;
            m_frames = '0; m_data = '0; m_after_rst = 1'b1;
            for (int i = 0; i < NCH; i++) m_cnt[i] = i;
        end else begin
            m_after_rst = 1'b0;
            if (!m_valid) begin
                if (a_enable) begin
                    m_valid = 1'b1; m_beat = 0; m_mode = dec_mode(a_mode);
                    model_load();
                end
            end else if (a_tready) begin
                ch = m_beat % NCH;
                if (m_mode == 0) m_cnt[ch] = (m_cnt[ch] + 1) % 256;
                if (m_mode == 1) m_lfsr = lfsr8_step(m_lfsr);
                if (m_beat == NBEAT - 1) begin
                    m_frames = m_frames + 32'd1;
                    m_beat   = 0;
                    if (a_enable) begin
                        m_mode = dec_mode(a_mode);
                        model_load();
                    end else begin
                        m_valid = 1'b0;
                    end
                end else begin
                    m_beat++;
                    model_load();
                end
            end
        end
    endtask

    task automatic compare_a();
        check("tvalid", 32'(a_tvalid), 32'(m_valid));
        check("frames_sent", a_frames, m_frames);
        if (m_valid || m_after_rst) begin
            check("tdata", 32'(a_tdata), 32'(m_data));
            check("tid", 32'(a_tid), m_valid ? 32'(m_beat % NCH) : 32'd0);
            check("tlast", 32'(a_tlast), 32'(m_valid && (m_beat == NBEAT - 1)));
        end
    endtask

    task automatic step_a(input logic r, input logic en, input logic [1:0] md,
                          input logic rdy, input logic [7:0] cv);
        a_rst = r; a_enable = en; a_mode = md; a_tready = rdy; a_const = cv;
        @(posedge clk);
        model_edge();
        #1;
        compare_a();
    endtask

    int exp_b_data [7] = '{0, 1, 2, 3, 4, 0, 1};
    int exp_b_last [7] = '{0, 0, 1, 0, 0, 1, 0};

    initial begin
        // Reset state
        repeat (2) step_a(1'b1, 1'b0, 2'd0, 1'b0, 8'h00);

        // Counter pattern, enable held, tready=1: 0,1,2,3,1,2,3,4 then next frame
        repeat (10) step_a(1'b0, 1'b1, 2'd0, 1'b1, 8'h00);
        check("count_frames_after_first", a_frames, 32'd1);

        // Presenting beat 3 of the frame, then enable drops: frame must complete
        step_a(1'b0, 1'b1, 2'd0, 1'b1, 8'h00);
        repeat (8) step_a(1'b0, 1'b0, 2'd0, 1'b1, 8'h00);
        check("drop_idle_tvalid", 32'(a_tvalid), 32'd0);
        check("drop_frames", a_frames, 32'd2);

        // COUNT -> CONST mid-frame, then back to COUNT
        repeat (4)  step_a(1'b0, 1'b1, 2'd0, 1'b1, 8'hA5);
        repeat (13) step_a(1'b0, 1'b1, 2'd2, 1'b1, 8'hA5);
        repeat (10) step_a(1'b0, 1'b1, 2'd0, 1'b1, 8'hA5);
        repeat (10) step_a(1'b0, 1'b0, 2'd0, 1'b1, 8'h00);

        // LFSR with pseudo-random backpressure
        repeat (200) step_a(1'b0, 1'b1, 2'd1, 1'($urandom_range(0, 1)), 8'h00);
        repeat (12) step_a(1'b0, 1'b0, 2'd1, 1'b1, 8'h00);

        // Reset during a stall mid-frame
        repeat (3) step_a(1'b0, 1'b1, 2'd0, 1'b1, 8'h00);
        repeat (3) step_a(1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        step_a(1'b1, 1'b1, 2'd0, 1'b0, 8'h00);
        check("rst_stall_tvalid", 32'(a_tvalid), 32'd0);
        step_a(1'b0, 1'b1, 2'd0, 1'b1, 8'h00);
        check("restart_tid", 32'(a_tid), 32'd0);
        check("restart_tdata", 32'(a_tdata), 32'd0);
        check("restart_frames", a_frames, 32'd0);

        // Random soak over all inputs
        repeat (400) begin
            step_a(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) != 0),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Instance B: RANGE=5 wrap on a single channel
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        check("b_reset_tvalid", 32'(b_tvalid), 32'd0);
        b_rst = 1'b0; b_enable = 1'b1; b_tready = 1'b1; b_mode = 2'd0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check("b_tvalid", 32'(b_tvalid), 32'd1);
            check("b_tdata", 32'(b_tdata), 32'(exp_b_data[i]));
            check("b_tlast", 32'(b_tlast), 32'(exp_b_last[i]));
            check("b_tid", 32'(b_tid), 32'd0);
        end
        check("b_frames", b_frames, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
